pipe_de_stage: RTL and testbench
================================

Name: pipe_de_stage

Overview:
- Parametrised successor to the fixed ID/EX pipeline register: carries the decode-stage bundle (controls, operands, immediate, dest reg, pc+4) into execute.
- Adds valid/ready elastic handshake with a one-entry skid buffer (full throughput under back-pressure), synchronous flush for branch/jump squash, bubble-safe control outputs and saturating performance counters.
- Sits between the decode and execute stages of the pipelined CPU; the hazard unit drives flush and e_ready.

Parameters:
- DATA_W, 32, width of da/db/dimm/dpc4 and matching e* outputs
- RN_W, 5, destination register index width
- ALUC_W, 4, ALU control width
- CNT_W, 16, width of bubble_cnt and stall_cnt (saturating)

Ports:
- clk  in  1  clock; all state updates on posedge
- clrn  in  1  reset; synchronous, active-high (clrn=1 at posedge clk resets)
- flush  in  1  synchronous squash of all held and incoming entries
- d_valid  in  1  decode bundle valid
- d_ready  out  1  stage can accept; registered, = (state != SKID)
- dwreg, dm2reg, dwmem, daluimm, dshift, djal  in  1 each  decode controls
- daluc  in  ALUC_W  ALU control
- da, db, dimm, dpc4  in  DATA_W each  operands, immediate, pc+4
- drn  in  RN_W  destination register
- e_valid  out  1  execute bundle valid
- e_ready  in  1  execute stage accepts
- ewreg, em2reg, ewmem, ealuimm, eshift, ejal  out  1 each  registered controls
- ealuc  out  ALUC_W; ea, eb, eimm, epc4  out  DATA_W; ern  out  RN_W
- bubble_cnt  out  CNT_W  cycles with e_valid=0
- stall_cnt  out  CNT_W  cycles with e_valid=1 and e_ready=0

Behaviour:
- Accept = d_valid & d_ready; release = e_valid & e_ready.
- Reset: state EMPTY, e_valid=0, d_ready=1, every e* output 0, main/skid entries 0, both counters 0. Reset dominates flush.
- States: EMPTY (no entry), FULL (main valid), SKID (main and skid valid).
- EMPTY: accept -> FULL, main <= d bundle.
- FULL: accept&release -> FULL, main <= d; accept&!release -> SKID, skid <= d; !accept&release -> EMPTY; neither -> hold.
- SKID: d_ready=0, so no accept; release -> FULL, main <= skid; else hold.
- Latency: d bundle accepted at edge N is visible on e* after edge N (one cycle). Throughput one bundle per cycle; ordering strictly FIFO.
- Outputs driven from main entry; e_valid=1 in FULL/SKID.
- Bubble-safe: when e_valid=0, ewreg, em2reg, ewmem, ejal forced 0; ealuc, ealuimm, eshift, ea, eb, eimm, ern, epc4 retain last main contents.
- flush=1 at an edge: next state EMPTY, main and skid discarded, any same-cycle accept dropped, e_valid=0 and d_ready=1 next cycle. Data fields untouched.
- flush while EMPTY: no effect beyond holding EMPTY.
- Counters: each non-reset edge, bubble_cnt += 1 if e_valid=0; stall_cnt += 1 if e_valid&!e_ready; both saturate at 2^CNT_W-1, never wrap; flush does not clear them.
- d_valid/e_ready may toggle arbitrarily; d_* with d_valid=0 ignored.

Decomposition:
- Package pipe_pkg: DATA_W/RN_W/ALUC_W defaults, state encoding (EMPTY/FULL/SKID), packed typedef de_bundle_t {wreg, m2reg, wmem, aluc, aluimm, a, b, imm, rn, shift, jal, pc4}.
- Sub-module pipe_skid_buf: generic width-parametrised valid/ready skid buffer with flush; pipe_de_stage packs/unpacks de_bundle_t, applies control masking, holds counters.

Test Plan:
- Reset: clrn=1 two cycles with d_valid=1 -> e_valid=0, d_ready=1, all e* 0, counters 0.
- Streaming: e_ready=1, bundles da=1..8 on consecutive cycles -> ea=1..8 one cycle later, no gaps, stall_cnt unchanged.
- Back-pressure: e_ready=0 after da=5 accepted, send da=6 -> SKID, d_ready=0; e_ready=1 -> ea=5 then 6, nothing lost or duplicated.
- Flush in SKID: entries da=7, da=8 held, flush=1 with d_valid=1 da=9 -> next cycle e_valid=0, ewreg=ewmem=0, d_ready=1; da=9 never appears.
- Bubble masking: accept dwreg=1,dwmem=1, release, then idle -> ewreg=ewmem=em2reg=ejal=0 while ea keeps last value.
- Counter saturation (CNT_W=4): 20 idle cycles -> bubble_cnt=15 held; simultaneous clrn=1 and flush=1 -> reset values.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the decode->execute pipeline register.
//   - default widths for the datapath, register index, ALU control and counters
//   - skid_state_e: occupancy encoding used by the elastic skid buffer
//   - de_bundle_t: default-width view of the decode bundle handed to execute
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RN_W   = 5;
  localparam int DEF_ALUC_W = 4;
  localparam int DEF_CNT_W  = 16;

  // EMPTY: nothing held; FULL: main entry valid; SKID: main and skid valid
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic                  wreg;
    logic                  m2reg;
    logic                  wmem;
    logic [DEF_ALUC_W-1:0] aluc;
    logic                  aluimm;
    logic [DEF_DATA_W-1:0] a;
    logic [DEF_DATA_W-1:0] b;
    logic [DEF_DATA_W-1:0] imm;
    logic [DEF_RN_W-1:0]   rn;
    logic                  shift;
    logic                  jal;
    logic [DEF_DATA_W-1:0] pc4;
  } de_bundle_t;

endpackage

// File: rtl/pipe_de_stage_if.sv
// pipe_de_stage_if: decode-side and execute-side signals of the DE stage.
//   master: decode stage + hazard unit (drives d_* bundle, d_valid, e_ready)
//   slave : the DE stage (drives d_ready, e_* bundle, e_valid, counters)
interface pipe_de_stage_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RN_W   = DEF_RN_W,
  parameter int ALUC_W = DEF_ALUC_W,
  parameter int CNT_W  = DEF_CNT_W
);

  // decode side
  logic              d_valid;
  logic              d_ready;
  logic              dwreg, dm2reg, dwmem, daluimm, dshift, djal;
  logic [ALUC_W-1:0] daluc;
  logic [DATA_W-1:0] da, db, dimm, dpc4;
  logic [RN_W-1:0]   drn;

  // execute side
  logic              e_valid;
  logic              e_ready;
  logic              ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
  logic [ALUC_W-1:0] ealuc;
  logic [DATA_W-1:0] ea, eb, eimm, epc4;
  logic [RN_W-1:0]   ern;

  // performance counters
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output d_valid, dwreg, dm2reg, dwmem, daluimm, dshift, djal,
           daluc, da, db, dimm, dpc4, drn, e_ready,
    input  d_ready, e_valid, ewreg, em2reg, ewmem, ealuimm, eshift, ejal,
           ealuc, ea, eb, eimm, epc4, ern, bubble_cnt, stall_cnt
  );

  modport slave (
    input  d_valid, dwreg, dm2reg, dwmem, daluimm, dshift, djal,
           daluc, da, db, dimm, dpc4, drn, e_ready,
    output d_ready, e_valid, ewreg, em2reg, ewmem, ealuimm, eshift, ejal,
           ealuc, ea, eb, eimm, epc4, ern, bubble_cnt, stall_cnt
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic one-entry-skid valid/ready register slice.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drops held entries and any same-cycle accept
//   in_valid/in_ready upstream handshake; in_ready is registered
//   in_data           upstream payload (W bits)
//   out_valid/out_ready downstream handshake
//   out_data          payload of the main (oldest) entry
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q, ready_d;
  logic         accept;
  logic         rel;

  always_comb begin
    accept  = in_valid & ready_q;
    rel     = (state_q != ST_EMPTY) & out_ready;
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
          main_d  = in_data;
        end
      end
      ST_FULL: begin
        if (accept && rel) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = ST_SKID;
          skid_d  = in_data;
        end else if (rel) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        // in_ready is low here, so only the drain path can fire
        if (rel) begin
          state_d = ST_FULL;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush only empties the slice; stored payload is left as-is so the
    // downstream data lines stay quiet during the squash.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    ready_d = (state_d != ST_SKID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/pipe_de_stage.sv
// pipe_de_stage: elastic ID/EX pipeline register.
// Ports:
//   clk    clock
//   clrn   synchronous active-high reset (dominates flush)
//   flush  squash held and incoming bundles (branch/jump redirect)
//   bus    pipe_de_stage_if.slave: d_* decode bundle with d_valid/d_ready,
//          e_* execute bundle with e_valid/e_ready, bubble_cnt, stall_cnt
// Architectural side-effect controls (wreg, m2reg, wmem, jal) are forced low
// while no bundle is presented; the other fields keep the last main entry.
module pipe_de_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RN_W   = DEF_RN_W,
  parameter int ALUC_W = DEF_ALUC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic             clk,
  input logic             clrn,
  input logic             flush,
  pipe_de_stage_if.slave  bus
);

  // Same field order as de_bundle_t, sized by this instance's parameters
  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic [ALUC_W-1:0] aluc;
    logic              aluimm;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [RN_W-1:0]   rn;
    logic              shift;
    logic              jal;
    logic [DATA_W-1:0] pc4;
  } bundle_t;

  localparam int BUNDLE_W = $bits(bundle_t);

  bundle_t          d_bundle;
  bundle_t          e_bundle;
  logic             e_valid;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    d_bundle        = '0;
    d_bundle.wreg   = bus.dwreg;
    d_bundle.m2reg  = bus.dm2reg;
    d_bundle.wmem   = bus.dwmem;
    d_bundle.aluc   = bus.daluc;
    d_bundle.aluimm = bus.daluimm;
    d_bundle.a      = bus.da;
    d_bundle.b      = bus.db;
    d_bundle.imm    = bus.dimm;
    d_bundle.rn     = bus.drn;
    d_bundle.shift  = bus.dshift;
    d_bundle.jal    = bus.djal;
    d_bundle.pc4    = bus.dpc4;
  end

  pipe_skid_buf #(
    .W(BUNDLE_W)
  ) u_skid (
    .clk      (clk),
    .rst      (clrn),
    .flush    (flush),
    .in_valid (bus.d_valid),
    .in_ready (bus.d_ready),
    .in_data  (d_bundle),
    .out_valid(e_valid),
    .out_ready(bus.e_ready),
    .out_data (e_bundle)
  );

  // Saturating counters: stop at all-ones rather than wrap
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (!e_valid && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
    if (e_valid && !bus.e_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.e_valid    = e_valid;
  assign bus.ewreg      = e_bundle.wreg  & e_valid;
  assign bus.em2reg     = e_bundle.m2reg & e_valid;
  assign bus.ewmem      = e_bundle.wmem  & e_valid;
  assign bus.ejal       = e_bundle.jal   & e_valid;
  assign bus.ealuc      = e_bundle.aluc;
  assign bus.ealuimm    = e_bundle.aluimm;
  assign bus.eshift     = e_bundle.shift;
  assign bus.ea         = e_bundle.a;
  assign bus.eb         = e_bundle.b;
  assign bus.eimm       = e_bundle.imm;
  assign bus.ern        = e_bundle.rn;
  assign bus.epc4       = e_bundle.pc4;
  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_de_stage.sv
// tb_pipe_de_stage: self-checking bench for pipe_de_stage.
// The reference model is a FIFO of at most two bundles plus the last bundle
// shown on the execute side; every negedge all outputs are compared to it.
module tb_pipe_de_stage;

  localparam int DATA_W  = 32;
  localparam int RN_W    = 5;
  localparam int ALUC_W  = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic clrn;
  logic flush;

  pipe_de_stage_if #(
    .DATA_W(DATA_W), .RN_W(RN_W), .ALUC_W(ALUC_W), .CNT_W(CNT_W)
  ) bus ();

  pipe_de_stage #(
    .DATA_W(DATA_W), .RN_W(RN_W), .ALUC_W(ALUC_W), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic [ALUC_W-1:0] aluc;
    logic              aluimm;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [RN_W-1:0]   rn;
    logic              shift;
    logic              jal;
    logic [DATA_W-1:0] pc4;
  } entry_t;

  entry_t fifo[$];
  entry_t shown;
  entry_t incoming;
  int     exp_bubble;
  int     exp_stall;
  bit     started = 0;
  bit     acc, rel;
  logic   exp_valid;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ctrl = {wreg, m2reg, wmem, aluimm, shift, jal}; other fields random
  task automatic applyStimulus(input logic v, input logic [31:0] a,
                               input logic er, input logic fl,
                               input logic [5:0] ctrl);
    bus.d_valid = v;
    bus.da      = a;
    bus.e_ready = er;
    flush       = fl;
    bus.dwreg   = ctrl[5];
    bus.dm2reg  = ctrl[4];
    bus.dwmem   = ctrl[3];
    bus.daluimm = ctrl[2];
    bus.dshift  = ctrl[1];
    bus.djal    = ctrl[0];
    bus.daluc   = ALUC_W'($urandom);
    bus.db      = $urandom;
    bus.dimm    = $urandom;
    bus.dpc4    = $urandom;
    bus.drn     = RN_W'($urandom);
  endtask

  // Reference model: advanced at each active edge from the sampled inputs
  always @(posedge clk) begin
    started = 1;
    if (clrn) begin
      fifo.delete();
      shown      = '0;
      exp_bubble = 0;
      exp_stall  = 0;
    end else begin
      if (fifo.size() == 0 && exp_bubble < CNT_MAX) exp_bubble++;
      if (fifo.size() != 0 && !bus.e_ready && exp_stall < CNT_MAX) exp_stall++;
      acc = bus.d_valid && (fifo.size() < 2);
      rel = (fifo.size() != 0) && bus.e_ready;
      incoming = '{wreg: bus.dwreg, m2reg: bus.dm2reg, wmem: bus.dwmem,
                   aluc: bus.daluc, aluimm: bus.daluimm, a: bus.da, b: bus.db,
                   imm: bus.dimm, rn: bus.drn, shift: bus.dshift, jal: bus.djal,
                   pc4: bus.dpc4};
      if (flush) begin
        fifo.delete();
      end else begin
        if (rel) void'(fifo.pop_front());
        if (acc) fifo.push_back(incoming);
      end
      if (fifo.size() != 0) shown = fifo[0];
    end
  end

  // Compare process: every output, every cycle
  always @(negedge clk) begin
    if (started) begin
      exp_valid = (fifo.size() != 0);
      checkOutput("e_valid",    64'(bus.e_valid),    64'(exp_valid));
      checkOutput("d_ready",    64'(bus.d_ready),    64'(fifo.size() < 2));
      checkOutput("ewreg",      64'(bus.ewreg),      64'(shown.wreg  & exp_valid));
      checkOutput("em2reg",     64'(bus.em2reg),     64'(shown.m2reg & exp_valid));
      checkOutput("ewmem",      64'(bus.ewmem),      64'(shown.wmem  & exp_valid));
      checkOutput("ejal",       64'(bus.ejal),       64'(shown.jal   & exp_valid));
      checkOutput("ealuimm",    64'(bus.ealuimm),    64'(shown.aluimm));
      checkOutput("eshift",     64'(bus.eshift),     64'(shown.shift));
      checkOutput("ealuc",      64'(bus.ealuc),      64'(shown.aluc));
      checkOutput("ea",         64'(bus.ea),         64'(shown.a));
      checkOutput("eb",         64'(bus.eb),         64'(shown.b));
      checkOutput("eimm",       64'(bus.eimm),       64'(shown.imm));
      checkOutput("ern",        64'(bus.ern),        64'(shown.rn));
      checkOutput("epc4",       64'(bus.epc4),       64'(shown.pc4));
      checkOutput("bubble_cnt", 64'(bus.bubble_cnt), 64'(exp_bubble));
      checkOutput("stall_cnt",  64'(bus.stall_cnt),  64'(exp_stall));
    end
  end

  initial begin
    // Reset with d_valid high for two cycles
    clrn = 1'b1;
    applyStimulus(1'b1, 32'hAA, 1'b1, 1'b0, 6'h3F);
    repeat (2) @(negedge clk);
    checkOutput("rst_e_valid", 64'(bus.e_valid),    64'd0);
    checkOutput("rst_d_ready", 64'(bus.d_ready),    64'd1);
    checkOutput("rst_ea",      64'(bus.ea),         64'd0);
    checkOutput("rst_ewreg",   64'(bus.ewreg),      64'd0);
    checkOutput("rst_bubble",  64'(bus.bubble_cnt), 64'd0);
    checkOutput("rst_stall",   64'(bus.stall_cnt),  64'd0);
    clrn = 1'b0;

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b1, 1'b0, 6'($urandom));
      @(negedge clk);
      checkOutput("stream_ea",    64'(bus.ea),      64'(i));
      checkOutput("stream_valid", 64'(bus.e_valid), 64'd1);
    end
    checkOutput("stream_stall", 64'(bus.stall_cnt), 64'd0);

    // Back-pressure into the skid entry
    applyStimulus(1'b1, 32'd5, 1'b1, 1'b0, 6'h00);
    @(negedge clk);
    checkOutput("bp_ea5", 64'(bus.ea), 64'd5);
    applyStimulus(1'b1, 32'd6, 1'b0, 1'b0, 6'h00);
    @(negedge clk);
    checkOutput("bp_skid_ready", 64'(bus.d_ready), 64'd0);
    checkOutput("bp_skid_ea",    64'(bus.ea),      64'd5);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 6'h00);
    @(negedge clk);
    checkOutput("bp_ea6",    64'(bus.ea),      64'd6);
    checkOutput("bp_valid6", 64'(bus.e_valid), 64'd1);
    @(negedge clk);
    checkOutput("bp_drained", 64'(bus.e_valid), 64'd0);
    checkOutput("bp_keep_ea", 64'(bus.ea),      64'd6);

    // Flush while in SKID with a new bundle offered
    applyStimulus(1'b1, 32'd7, 1'b0, 1'b0, 6'h28);
    @(negedge clk);
    applyStimulus(1'b1, 32'd8, 1'b0, 1'b0, 6'h28);
    @(negedge clk);
    checkOutput("fl_skid", 64'(bus.d_ready), 64'd0);
    applyStimulus(1'b1, 32'd9, 1'b0, 1'b1, 6'h28);
    @(negedge clk);
    checkOutput("fl_valid", 64'(bus.e_valid), 64'd0);
    checkOutput("fl_ready", 64'(bus.d_ready), 64'd1);
    checkOutput("fl_ewreg", 64'(bus.ewreg),   64'd0);
    checkOutput("fl_ewmem", 64'(bus.ewmem),   64'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 6'h00);
    repeat (3) begin
      @(negedge clk);
      checkOutput("fl_no9", 64'(bus.e_valid), 64'd0);
    end

    // Bubble masking of side-effect controls
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 6'h3F);
    @(negedge clk);
    checkOutput("mask_ewreg_on", 64'(bus.ewreg), 64'd1);
    checkOutput("mask_ewmem_on", 64'(bus.ewmem), 64'd1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 6'h00);
    repeat (2) @(negedge clk);
    checkOutput("mask_ewreg",  64'(bus.ewreg),  64'd0);
    checkOutput("mask_ewmem",  64'(bus.ewmem),  64'd0);
    checkOutput("mask_em2reg", 64'(bus.em2reg), 64'd0);
    checkOutput("mask_ejal",   64'(bus.ejal),   64'd0);
    checkOutput("mask_shift",  64'(bus.eshift), 64'd1);
    checkOutput("mask_ea",     64'(bus.ea),     64'h55);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 1500; i++) begin
      clrn = ($urandom_range(0, 199) == 0);
      applyStimulus(($urandom_range(0, 9) < 7), $urandom,
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0),
                    6'($urandom));
      @(negedge clk);
    end
    clrn = 1'b0;

    // Counter saturation, then reset racing a flush
    clrn = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 6'h00);
    @(negedge clk);
    clrn = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("sat_bubble", 64'(bus.bubble_cnt), 64'd15);
    checkOutput("sat_stall",  64'(bus.stall_cnt),  64'd0);
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b0, 6'h3F);
    @(negedge clk);
    checkOutput("sat_hold", 64'(bus.bubble_cnt), 64'd15);
    clrn = 1'b1;
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b1, 6'h3F);
    @(negedge clk);
    checkOutput("rf_bubble", 64'(bus.bubble_cnt), 64'd0);
    checkOutput("rf_valid",  64'(bus.e_valid),    64'd0);
    checkOutput("rf_ea",     64'(bus.ea),         64'd0);
    checkOutput("rf_ready",  64'(bus.d_ready),    64'd1);
    clrn = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 6'h00);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
